// File: rtl/store_buffer.sv
// Posted store buffer between the core data port and data memory: stores are
// queued in program order and drained over a valid/ready handshake.
// Optional STORE_BUFFER_COALESCE_EN merges a store into the youngest entry when the addresses match.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [AW-1:0]            dataadr,
    input  logic [DW-1:0]            writedata,
    output logic                     stall,
    output logic                     mem_valid,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] occ_reg;
    logic [CW-1:0] occ_next;
    logic [PW-1:0] last_idx;
    logic          full;
    logic          enq;
    logic          deq;
    logic          merge;

    assign last_idx  = tail_reg - 1'b1;
    assign full      = (occ_reg == CW'(DEPTH));
    assign mem_valid = (occ_reg != '0);
    assign deq       = mem_valid & mem_ready;

`ifdef STORE_BUFFER_COALESCE_EN
    // The youngest entry may be merged into unless it is also the head leaving this cycle.
    assign merge = memwrite && (occ_reg != '0) && (addr_mem[last_idx] == dataadr)
                   && !((occ_reg == CW'(1)) && deq);
`else
    assign merge = 1'b0;
`endif

    // A same-cycle dequeue does not make room for this cycle's store.
    assign stall = memwrite & full & ~merge;
    assign enq   = memwrite & ~full & ~merge;

    assign mem_addr  = mem_valid ? addr_mem[head_reg] : '0;
    assign mem_wdata = mem_valid ? data_mem[head_reg] : '0;
    assign occupancy = occ_reg;
    assign empty     = (occ_reg == '0);

    always_comb begin
        occ_next = occ_reg;
        case ({enq, deq})
            2'b10:   occ_next = occ_reg + 1'b1;
            2'b01:   occ_next = occ_reg - 1'b1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
        end else begin
            if (enq) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (deq) begin
                head_reg <= head_reg + 1'b1;
            end
            occ_reg <= occ_next;
        end
    end

    // Entry storage carries no reset; the outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail_reg] <= dataadr;
            data_mem[tail_reg] <= writedata;
        end else if (merge) begin
            data_mem[last_idx] <= writedata;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stores push expected memory writes, and a
// forked monitor pops and compares every accepted write.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        stall;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [2:0]  occupancy;
    logic        empty;

    int n_cmp;
    int n_err;
    logic [63:0] expq [$];

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .stall     (stall),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .occupancy (occupancy),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Watches memory writes at the falling edge and checks handshake stability.
    task automatic monitor_loop();
        logic        hold_prev;
        logic [31:0] addr_prev;
        logic [31:0] data_prev;
        logic [63:0] e;
        hold_prev = 1'b0;
        addr_prev = '0;
        data_prev = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("hold_addr", mem_addr, addr_prev);
                    chk("hold_data", mem_wdata, data_prev);
                end
                if (mem_valid && mem_ready) begin
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                                 mem_addr, mem_wdata);
                    end else begin
                        e = expq.pop_front();
                        chk("wr_addr", mem_addr, e[63:32]);
                        chk("wr_data", mem_wdata, e[31:0]);
                    end
                end
                hold_prev = mem_valid && !mem_ready;
                addr_prev = mem_addr;
                data_prev = mem_wdata;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the store is taken, memwrite low.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input bit push);
        int k;
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        if (push) expq.push_back({a, d});
        k = 0;
        @(negedge clk);
        while (stall && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (stall) chk("store_timeout", 32'(stall), 32'd0);
        @(posedge clk); #1;
        memwrite = 1'b0;
    endtask

    task automatic drain();
        int k;
        mem_ready = 1'b1;
        k = 0;
        while (expq.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_left", 32'(expq.size()), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_occ", 32'(occupancy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
        mem_ready = 1'b0;
        fork
            monitor_loop();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_data", mem_wdata, 32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // Two back-to-back stores with memory always ready
        mem_ready = 1'b1;
        store(32'd80, 32'h5, 1'b1);
        store(32'd84, 32'h7, 1'b1);
        drain();

        // Fill, stall on the fifth store, then release
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) store(32'h10 + 32'(4 * i), 32'(i + 1), 1'b1);
        @(negedge clk);
        chk("full_nowrite_stall", 32'(stall), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd4);
        @(posedge clk); #1;
        memwrite  = 1'b1;
        dataadr   = 32'h20;
        writedata = 32'h5;
        expq.push_back({32'h20, 32'h5});
        @(negedge clk);
        chk("full_stall", 32'(stall), 32'd1);
        chk("full_occ2", 32'(occupancy), 32'd4);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("stall_with_deq", 32'(stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_released", 32'(stall), 32'd0);
        chk("occ_after_deq", 32'(occupancy), 32'd3);
        @(posedge clk); #1;
        memwrite = 1'b0;
        @(negedge clk);
        chk("occ_enq_deq", 32'(occupancy), 32'd3);
        @(posedge clk); #1;
        drain();

        // Simultaneous enqueue and dequeue at occupancy 2
        mem_ready = 1'b0;
        store(32'h40, 32'h11, 1'b1);
        store(32'h44, 32'h22, 1'b1);
        memwrite  = 1'b1;
        dataadr   = 32'h48;
        writedata = 32'h33;
        mem_ready = 1'b1;
        expq.push_back({32'h48, 32'h33});
        @(negedge clk);
        chk("occ2_before", 32'(occupancy), 32'd2);
        @(posedge clk); #1;
        memwrite  = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("occ2_after", 32'(occupancy), 32'd2);
        @(posedge clk); #1;
        drain();

        // Ten stores streaming through, wrapping the pointers several times
        for (int i = 0; i < 10; i++) store(32'h200 + 32'(4 * i), 32'h300 + 32'(i), 1'b1);
        drain();

        // Ready toggling every cycle
        mem_ready = 1'b0;
        fork
            begin
                repeat (40) begin
                    @(posedge clk); #1;
                    mem_ready = ~mem_ready;
                end
            end
            begin
                for (int i = 0; i < 8; i++) store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1);
            end
        join
        drain();

`ifdef STORE_BUFFER_COALESCE_EN
        // Same-address stores merge into the youngest entry
        mem_ready = 1'b0;
        store(32'd84, 32'h7, 1'b0);
        store(32'd84, 32'h9, 1'b0);
        expq.push_back({32'd84, 32'h9});
        @(negedge clk);
        chk("merge_occ", 32'(occupancy), 32'd1);
        @(posedge clk); #1;
        drain();

        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) store(32'h10 + 32'(4 * i), 32'(i + 1), 1'b1);
        store(32'h1C, 32'h4, 1'b0);
        expq.push_back({32'h1C, 32'h99});
        memwrite  = 1'b1;
        dataadr   = 32'h1C;
        writedata = 32'h99;
        @(negedge clk);
        chk("merge_full_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        memwrite = 1'b0;
        @(negedge clk);
        chk("merge_full_occ", 32'(occupancy), 32'd4);
        @(posedge clk); #1;
        drain();
`endif

        // Reset while three stores are queued
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) store(32'h60 + 32'(4 * i), 32'h70 + 32'(i), 1'b1);
        @(negedge clk);
        chk("pre_rst_occ", 32'(occupancy), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(mem_valid), 32'd0);
        chk("midrst_occ", 32'(occupancy), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        expq.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("postrst_valid", 32'(mem_valid), 32'd0);
        chk("final_queue", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted write buffer between the MIPS core data port (memwrite, dataadr, writedata) and data memory.
- Each core store is queued in a FIFO and drained to memory in program order over a valid/ready handshake.
- When the buffer is full the core stalls, so memory latency is hidden from the single-cycle datapath.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2.
AW, 32, address width.
DW, 32, data width.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
memwrite  in  1  core store strobe for the current cycle.
dataadr  in  AW  core store address.
writedata  in  DW  core store data.
stall  out  1  combinational; core must hold its store and retry next cycle.
mem_valid  out  1  head entry is presented to memory.
mem_addr  out  AW  head entry address.
mem_wdata  out  DW  head entry data.
mem_ready  in  1  memory accepts the head entry this cycle.
occupancy  out  $clog2(DEPTH)+1  number of valid entries.
empty  out  1  occupancy == 0.

Behaviour:
- Reset (async assert, sync release):
  - Pointers and occupancy clear to 0.
  - mem_valid=0, empty=1, stall=0.
  - mem_addr and mem_wdata read 0.
  - Reset mid-drain discards all queued stores; nothing partial is retained.
- Storage: circular array with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
- Enqueue (enq) = memwrite & !stall. At the clock edge it writes {dataadr, writedata} to the tail and increments the tail. No address alignment check; the address is stored verbatim.
- Dequeue (deq) = mem_valid & mem_ready. At the edge it increments the head.
- Occupancy:
  - enq only: +1.
  - deq only: -1.
  - enq and deq together: unchanged, both pointers advance.
  - Occupancy never exceeds DEPTH and never goes below 0.
- mem_valid = (occupancy != 0). mem_addr and mem_wdata are driven directly from the head entry.
- Handshake: while mem_valid=1 and mem_ready=0, mem_addr and mem_wdata hold stable. mem_ready while mem_valid=0 is ignored.
- Latency: a store enqueued at edge N into an empty buffer presents mem_valid=1 from edge N until its accepting edge. Minimum one cycle of residence; no combinational core-to-memory bypass.
- stall = memwrite & (occupancy == DEPTH).
  - A dequeue in the same cycle does not free space for that cycle's store. The store is taken on the next edge.
  - stall is 0 whenever memwrite=0.
- Ordering: strict FIFO. Memory sees stores in the exact order accepted from the core.
- empty = (occupancy == 0).

Optional Feature:
Macro STORE_BUFFER_COALESCE_EN.
- Defined: a store whose dataadr equals the most recently enqueued entry's address is merged, provided that entry is valid and is not the head being dequeued in the same cycle:
  - writedata overwrites that entry's data;
  - occupancy and pointers are unchanged;
  - stall is suppressed for a merge, even when full.
- Defined, occupancy==1 with deq in the same cycle: no merge; the store enqueues as a normal entry.
- Not defined: every store occupies its own entry; the behaviour is exactly as above.

Test Plan:
1. Reset with mem_ready=0 -> mem_valid=0, empty=1, occupancy=0, stall=0. Assert reset mid-drain with 3 entries queued -> mem_valid falls immediately with no clock edge; occupancy=0.
2. mem_ready=1; store (80,0x5) then (84,0x7) on consecutive cycles -> memory accepts addr 80 data 5, then addr 84 data 7, one per cycle; empty=1 afterwards.
3. mem_ready=0; 4 stores (0x10..0x1C, data 1..4), then a 5th store (0x20,5) -> stall=1 on the 5th and occupancy=4. Raise mem_ready -> the 5th store is enqueued the cycle after the first dequeue; drain order is 1,2,3,4,5.
4. occupancy=2 with simultaneous enq and deq -> occupancy stays 2; wrap-around across entry DEPTH-1 to 0 preserves order over 10 consecutive stores.
5. mem_ready toggling 0/1 every cycle -> mem_addr and mem_wdata are stable throughout every ready-low cycle; no entry is lost or duplicated.
6. With STORE_BUFFER_COALESCE_EN defined:
   - Stores (84,7) then (84,9) while mem_ready=0 -> occupancy=1; memory later receives a single write, 84/9.
   - Full buffer with tail address 0x1C, then a store to 0x1C -> stall=0 and the tail data is updated.
